// File: rtl/gpio_reg_initiator.sv
// gpio_reg_initiator
//   Turns a valid/ready command stream into single-cycle emesh register
//   accesses (reg_access + reg_packet) for gpio-style register slaves.
//   Read data returns from the slave RLAT cycles after the access. It is
//   captured and then presented on a valid/ready response channel. Only one
//   transaction is in flight at a time.
// Ports
//   clk, nreset          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr[AW-1:0]     destination address, passed through unchanged
//   cmd_data[31:0]       write data
//   reg_access           one-cycle access strobe
//   reg_packet[PW-1:0]   emesh packet, qualified only by reg_access
//   reg_rdata[31:0]      slave readback
//   rsp_valid/rsp_ready  read response handshake
//   rsp_data[31:0]       captured read data
//   busy                 high whenever the FSM is not idle
module gpio_reg_initiator #(
  parameter int          AW       = 32,
  parameter int          PW       = 2*AW+40,
  parameter int          RLAT     = 1,
  parameter logic [31:0] SRCADDR  = 32'h0,
  parameter logic [4:0]  CTRLMODE = 5'h0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_data,
  output logic          reg_access,
  output logic [PW-1:0] reg_packet,
  input  logic [31:0]   reg_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          busy
);

  localparam int CW = $clog2(RLAT) + 1;
  localparam int SW = PW - 2*AW - 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          cur_write;
  logic [CW-1:0] cnt;
  logic [AW-1:0] data_ext;
  logic [PW-1:0] next_packet;

  always_comb begin
    data_ext    = AW'(cmd_data);
    next_packet = {SW'(SRCADDR), data_ext, cmd_addr, CTRLMODE, 2'b10, cmd_write};
  end

  // All outputs are registered: each transition loads the output values
  // that belong to the state being entered.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      cur_write  <= 1'b0;
      cnt        <= '0;
      cmd_ready  <= 1'b0;
      reg_access <= 1'b0;
      reg_packet <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cur_write  <= cmd_write;
            reg_packet <= next_packet;
            reg_access <= 1'b1;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end else begin
            // cmd_ready comes up on the first edge after reset release
            cmd_ready <= 1'b1;
          end
        end
        ISSUE: begin
          reg_access <= 1'b0;
          if (cur_write) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt   <= CW'(RLAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= reg_rdata;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_reg_initiator.sv
module tb_gpio_reg_initiator;

  localparam logic [31:0] SRC1 = 32'hCAFE_0001;
  localparam logic [4:0]  CM1  = 5'h15;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RLAT=1 instance
  logic         cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0]  cmd_addr = '0, cmd_data = '0;
  logic         cmd_ready, reg_access, rsp_valid, busy;
  logic [103:0] reg_packet;
  logic [31:0]  reg_rdata, rsp_data;

  // RLAT=3 instance
  logic         cmd_valid3 = 1'b0, cmd_write3 = 1'b0, rsp_ready3 = 1'b0;
  logic [31:0]  cmd_addr3 = '0, cmd_data3 = '0;
  logic         cmd_ready3, reg_access3, rsp_valid3, busy3;
  logic [103:0] reg_packet3;
  logic [31:0]  reg_rdata3, rsp_data3;

  gpio_reg_initiator #(.AW(32), .PW(104), .RLAT(1), .SRCADDR(SRC1), .CTRLMODE(CM1)) dut1 (
    .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .reg_access(reg_access), .reg_packet(reg_packet), .reg_rdata(reg_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy));

  gpio_reg_initiator #(.AW(32), .PW(104), .RLAT(3)) dut3 (
    .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_write(cmd_write3), .cmd_addr(cmd_addr3), .cmd_data(cmd_data3),
    .reg_access(reg_access3), .reg_packet(reg_packet3), .reg_rdata(reg_rdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .busy(busy3));

  // Slave models: 16-word register file indexed by addr[5:2]; read data is
  // present only in the cycle RLAT cycles after the access, zero otherwise.
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  logic [31:0] rd1 = '0;
  logic [31:0] pipe3 [3] = '{32'h0, 32'h0, 32'h0};

  always @(posedge clk) begin
    if (reg_access && reg_packet[0]) mem1[reg_packet[13:10]] <= reg_packet[71:40];
    rd1 <= (reg_access && !reg_packet[0]) ? mem1[reg_packet[13:10]] : 32'h0;
    if (reg_access3 && reg_packet3[0]) mem3[reg_packet3[13:10]] <= reg_packet3[71:40];
    pipe3[0] <= (reg_access3 && !reg_packet3[0]) ? mem3[reg_packet3[13:10]] : 32'h0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign reg_rdata  = rd1;
  assign reg_rdata3 = pipe3[2];

  function automatic logic [103:0] pkt(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                       input logic [31:0] src, input logic [4:0] cm);
    return {src, d, a, cm, 2'b10, wr};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the access cycle.
  task automatic issue1(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int unsigned n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("accept_timeout", 128'(cmd_ready), 128'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic issue3(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int unsigned n = 0;
    cmd_valid3 = 1'b1; cmd_write3 = wr; cmd_addr3 = a; cmd_data3 = d;
    while (!cmd_ready3 && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready3) chk("accept3_timeout", 128'(cmd_ready3), 128'(1));
    @(negedge clk);
    cmd_valid3 = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs = '{
      '{1'b1, 32'h0000_0004, 32'hA5A5_0F0F, 32'h0},
      '{1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0},
      '{1'b1, 32'h0000_003C, 32'h0000_FFFF, 32'h0},
      '{1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678},
      '{1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_0F0F},
      '{1'b1, 32'h0000_0704, 32'hFFFF_FFFF, 32'h0},
      '{1'b0, 32'h0000_003C, 32'h0,         32'h0000_FFFF},
      '{1'b0, 32'h0000_0004, 32'h0,         32'hFFFF_FFFF}
    };

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("rst_access", 128'(reg_access), 128'(0));
    chk("rst_packet", 128'(reg_packet), 128'(0));
    chk("rst_rsp", 128'({rsp_valid, rsp_data, busy}), 128'(0));
    nreset = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rel_busy", 128'(busy), 128'(0));

    // Table-driven single transactions on the RLAT=1 instance
    for (int i = 0; i < 8; i++) begin
      issue1(vecs[i].wr, vecs[i].addr, vecs[i].data);
      chk("v_access", 128'(reg_access), 128'(1));
      chk("v_packet", 128'(reg_packet), 128'(pkt(vecs[i].wr, vecs[i].addr, vecs[i].data, SRC1, CM1)));
      chk("v_ready_lo", 128'({cmd_ready, busy}), 128'(2'b01));
      @(negedge clk);
      chk("v_access_off", 128'(reg_access), 128'(0));
      if (vecs[i].wr) begin
        chk("w_ready_hi", 128'({cmd_ready, busy, rsp_valid}), 128'(3'b100));
      end else begin
        chk("r_wait", 128'({rsp_valid, cmd_ready}), 128'(0));
        @(negedge clk);
        chk("r_valid", 128'(rsp_valid), 128'(1));
        chk("r_data", 128'(rsp_data), 128'(vecs[i].exp_rsp));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("r_done", 128'({rsp_valid, cmd_ready, busy}), 128'(3'b010));
      end
    end

    // Read with backpressure; rsp_ready high before rsp_valid has no effect
    issue1(1'b0, 32'h0000_0008, 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_early_ready", 128'(rsp_valid), 128'(0));
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_valid", 128'(rsp_valid), 128'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", 128'({rsp_valid, cmd_ready, reg_access, busy}), 128'(4'b1001));
      chk("bp_data", 128'(rsp_data), 128'(32'h1234_5678));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release", 128'({rsp_valid, cmd_ready, busy}), 128'(3'b010));

    // Back-to-back writes with cmd_valid held
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_data = 32'h1000_0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_access", 128'(reg_access), 128'(k % 2 == 0));
      chk("b2b_busy", 128'(busy), 128'(k % 2 == 0));
      if (k % 2 == 0) begin
        chk("b2b_packet", 128'(reg_packet),
            128'(pkt(1'b1, 32'h100 + 32'(k * 2), 32'h1000_0000 + 32'(k / 2), SRC1, CM1)));
        if (k == 6) cmd_valid = 1'b0;
        else begin
          cmd_addr = 32'h100 + 32'((k + 2) * 2);
          cmd_data = 32'h1000_0000 + 32'(k / 2 + 1);
        end
      end
    end

    // RLAT=3: data valid only on the 3rd cycle after the access
    issue3(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("l3_wpacket", 128'(reg_packet3), 128'(pkt(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 5'h0)));
    @(negedge clk);
    issue3(1'b0, 32'h0000_0010, 32'h0);
    chk("l3_raccess", 128'(reg_access3), 128'(1));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("l3_wait", 128'({rsp_valid3, busy3}), 128'(2'b01));
    end
    @(negedge clk);
    chk("l3_valid", 128'(rsp_valid3), 128'(1));
    chk("l3_data", 128'(rsp_data3), 128'(32'hDEAD_BEEF));
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;
    chk("l3_done", 128'({rsp_valid3, cmd_ready3}), 128'(2'b01));

    // Reset while in WAIT
    issue3(1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("mr_outputs", 128'({cmd_ready3, reg_access3, rsp_valid3, busy3}), 128'(0));
    chk("mr_data", 128'(rsp_data3), 128'(0));
    chk("mr_packet", 128'(reg_packet3), 128'(0));
    @(negedge clk);
    nreset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mr_after", 128'({cmd_ready3, reg_access3, rsp_valid3, busy3}), 128'(4'b1000));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
